// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding I-cache request feeding a QUEUE_DEPTH-entry FIFO to decode.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module inst_prefetch_queue #(
    parameter int                    ADDR_WIDTH       = 64,
    parameter int                    INST_WIDTH       = 32,
    parameter int                    QUEUE_DEPTH      = 4,
    parameter int                    LINE_OFFSET_BITS = 6,
    parameter logic [INST_WIDTH-1:0] NOP_INST         = 32'h01000000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDR_WIDTH-1:0]              entry,
    input  logic                               redirect_valid,
    input  logic [ADDR_WIDTH-1:0]              redirect_target,
    output logic                               ic_req,
    output logic [ADDR_WIDTH-LINE_OFFSET_BITS-1:0] ic_line_addr,
    output logic [LINE_OFFSET_BITS-3:0]        ic_word_select,
    input  logic                               ic_ack,
    input  logic [INST_WIDTH-1:0]              ic_data_out,
    output logic                               id_valid,
    input  logic                               id_ready,
    output logic [INST_WIDTH-1:0]              id_inst,
    output logic [ADDR_WIDTH-1:0]              id_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                        perf_fetched,
    output logic [31:0]                        perf_flushed
`endif
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   fetch_pc, fetch_pc_nxt;
    logic [ADDR_WIDTH-1:0]   req_pc;
    logic [ADDR_WIDTH-1:0]   target_aligned;
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [CW-1:0]           count;
    logic                    push, pop, flush;

    logic [INST_WIDTH-1:0]   inst_mem [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]   pc_mem   [QUEUE_DEPTH];

    assign target_aligned = {redirect_target[ADDR_WIDTH-1:2], 2'b00};

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        push         = 1'b0;
        flush        = 1'b0;
        unique case (state)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = target_aligned;
                    flush        = 1'b1;
                end else if (count < DEPTH_C) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = target_aligned;
                    flush        = 1'b1;
                    state_nxt    = ic_ack ? IDLE : DRAIN;
                end else if (ic_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + ADDR_WIDTH'(4);
                    state_nxt    = IDLE;
                end
            end
            DRAIN: begin
                // The queue is already empty here, so a redirect only retargets the fetch PC.
                if (redirect_valid) fetch_pc_nxt = target_aligned;
                if (ic_ack)         state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pop = id_valid && id_ready;

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= entry;
            req_pc   <= entry;
            ic_req   <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            ic_req   <= (state_nxt != IDLE);
            // The request address is frozen for the whole request, even if a redirect retargets fetch_pc.
            if (state == IDLE || state_nxt == IDLE) req_pc <= fetch_pc_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // NOTE: queue storage has no reset; entries are only observable once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= ic_data_out;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

    assign ic_line_addr   = req_pc[ADDR_WIDTH-1:LINE_OFFSET_BITS];
    assign ic_word_select = req_pc[LINE_OFFSET_BITS-1:2];

    assign id_valid = (count != '0);
    assign id_inst  = id_valid ? inst_mem[rd_ptr] : NOP_INST;
    assign id_pc    = id_valid ? pc_mem[rd_ptr]   : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [32:0] fetched_sum, flushed_sum;

    always_comb begin
        fetched_sum = {1'b0, perf_fetched} + 33'(push);
        flushed_sum = {1'b0, perf_flushed} + 33'(count) + 33'((state == REQ) && ic_ack);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= fetched_sum[32] ? 32'hFFFFFFFF : fetched_sum[31:0];
            if (flush) perf_flushed <= flushed_sum[32] ? 32'hFFFFFFFF : flushed_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_inst_prefetch_queue;

    localparam int          AW    = 64;
    localparam int          IW    = 32;
    localparam int          DEPTH = 4;
    localparam int          LOB   = 6;
    localparam logic [31:0] NOP   = 32'h01000000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [AW-1:0]   entry = 64'h1000;
    logic            redirect_valid = 1'b0;
    logic [AW-1:0]   redirect_target = '0;
    logic            ic_req;
    logic [AW-LOB-1:0] ic_line_addr;
    logic [LOB-3:0]  ic_word_select;
    logic            ic_ack = 1'b0;
    logic [IW-1:0]   ic_data_out = '0;
    logic            id_valid;
    logic            id_ready = 1'b0;
    logic [IW-1:0]   id_inst;
    logic [AW-1:0]   id_pc;

    inst_prefetch_queue dut (
        .clk             (clk),
        .reset           (reset),
        .entry           (entry),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ic_req          (ic_req),
        .ic_line_addr    (ic_line_addr),
        .ic_word_select  (ic_word_select),
        .ic_ack          (ic_ack),
        .ic_data_out     (ic_data_out),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_inst         (id_inst),
        .id_pc           (id_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc, inst}, the next fetch PC, and whether a request is outstanding
    // (and whether its data has been condemned by a redirect).
    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } ent_t;

    ent_t          q[$];
    bit            m_busy;
    bit            m_dead;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_req;

    task automatic model_reset(input logic [AW-1:0] e);
        q.delete();
        m_busy = 1'b0;
        m_dead = 1'b0;
        m_pc   = e;
        m_req  = e;
    endtask

    task automatic model_step(input logic rv, input logic [AW-1:0] tgt, input logic ack,
                              input logic [IW-1:0] data, input logic rdy);
        int pre;
        pre = q.size();
        if (rv) begin
            q.delete();
            m_pc = tgt & ~64'h3;
            if (m_busy) begin
                if (ack) begin
                    m_busy = 1'b0;
                    m_dead = 1'b0;
                end else begin
                    m_dead = 1'b1;
                end
            end
        end else begin
            if (pre != 0 && rdy) void'(q.pop_front());
            if (m_busy) begin
                if (ack) begin
                    if (!m_dead) begin
                        q.push_back('{pc: m_pc, inst: data});
                        m_pc = m_pc + 64'd4;
                    end
                    m_busy = 1'b0;
                    m_dead = 1'b0;
                end
            end else if (pre < DEPTH) begin
                m_busy = 1'b1;
                m_req  = m_pc;
            end
        end
    endtask

    task automatic compare_model();
        logic [AW-1:0] exp_line;
        check("ic_req", 64'(ic_req), 64'(m_busy));
        check("id_valid", 64'(id_valid), 64'(q.size() != 0));
        check("id_inst", 64'(id_inst), (q.size() != 0) ? 64'(q[0].inst) : 64'(NOP));
        check("id_pc", id_pc, (q.size() != 0) ? q[0].pc : 64'h0);
        if (m_busy) begin
            exp_line = m_req >> LOB;
            check("ic_line_addr", 64'(ic_line_addr), exp_line);
            check("ic_word_select", 64'(ic_word_select), 64'(m_req[LOB-1:2]));
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) compare_model();
    end

    // Drive one cycle of inputs, let the edge happen, advance the model, and return at the next negedge.
    task automatic cycle(input logic rv, input logic [AW-1:0] tgt, input logic ack,
                         input logic [IW-1:0] data, input logic rdy);
        #1;
        redirect_valid  = rv;
        redirect_target = tgt;
        ic_ack          = ack;
        ic_data_out     = data;
        id_ready        = rdy;
        @(posedge clk);
        model_step(rv, tgt, ack, data, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [AW-1:0] e);
        #1;
        reset          = 1'b1;
        entry          = e;
        redirect_valid = 1'b0;
        ic_ack         = 1'b0;
        id_ready       = 1'b0;
        model_reset(e);
        @(negedge clk);
        check("reset_ic_req", 64'(ic_req), 64'h0);
        check("reset_id_inst", 64'(id_inst), 64'(NOP));
        #1;
        reset = 1'b0;
    endtask

    initial begin
        model_reset(64'h1000);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;

        // 1: basic sequential fetch with a two-cycle cache latency.
        do_reset(64'h1000);
        cycle(0, 0, 0, 0, 1);
        check("t1_req", 64'(ic_req), 64'h1);
        check("t1_line0", 64'(ic_line_addr), 64'h40);
        check("t1_word0", 64'(ic_word_select), 64'h0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 32'hA5A50001, 1);
        check("t1_pc0", id_pc, 64'h1000);
        check("t1_inst0", 64'(id_inst), 64'hA5A50001);
        cycle(0, 0, 0, 0, 1);
        check("t1_word1", 64'(ic_word_select), 64'h1);
        check("t1_empty", 64'(id_valid), 64'h0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 32'hA5A50002, 1);
        check("t1_pc1", id_pc, 64'h1004);
        check("t1_inst1", 64'(id_inst), 64'hA5A50002);

        // 2: fill the queue with decode stalled, then drain it.
        do_reset(64'h1000);
        for (int i = 0; i < 12; i++) cycle(0, 0, m_busy, 32'hB0000000 + 32'(i), 0);
        check("t2_full_noreq", 64'(ic_req), 64'h0);
        check("t2_full_valid", 64'(id_valid), 64'h1);
        for (int i = 0; i < 4; i++) begin
            check("t2_pop_pc", id_pc, 64'h1000 + 64'(4 * i));
            cycle(0, 0, 0, 0, 1);
        end
        check("t2_drained", 64'(id_valid), 64'h0);
        check("t2_resume_req", 64'(ic_req), 64'h1);
        check("t2_resume_word", 64'(ic_word_select), 64'h4);
        check("t2_resume_line", 64'(ic_line_addr), 64'h40);

        // 3: redirect while a request is outstanding -> drain the stale response.
        do_reset(64'h1000);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 64'h2000, 0, 0, 1);
        check("t3_drain_req", 64'(ic_req), 64'h1);
        check("t3_drain_line", 64'(ic_line_addr), 64'h40);
        cycle(0, 0, 0, 0, 1);
        check("t3_drain_hold", 64'(ic_req), 64'h1);
        cycle(0, 0, 1, 32'hDEADBEEF, 1);
        check("t3_no_push", 64'(id_valid), 64'h0);
        cycle(0, 0, 0, 0, 1);
        check("t3_new_line", 64'(ic_line_addr), 64'h80);
        check("t3_new_word", 64'(ic_word_select), 64'h0);
        cycle(0, 0, 1, 32'h12340000, 0);
        check("t3_first_pc", id_pc, 64'h2000);

        // 4: redirect coinciding with an ack while two entries are queued.
        do_reset(64'h1000);
        for (int i = 0; i < 5; i++) cycle(0, 0, m_busy, 32'hC0000000 + 32'(i), 0);
        check("t4_pre_req", 64'(ic_req), 64'h1);
        cycle(1, 64'h3003, 1, 32'hFFFF0000, 0);
        check("t4_flushed", 64'(id_valid), 64'h0);
        check("t4_nop", 64'(id_inst), 64'(NOP));
        check("t4_idle", 64'(ic_req), 64'h0);
        cycle(0, 0, 0, 0, 0);
        check("t4_tgt_line", 64'(ic_line_addr), 64'hC0);
        check("t4_tgt_word", 64'(ic_word_select), 64'h0);

        // 5: fetch PC wraps past the top of the address space.
        do_reset(64'hFFFFFFFFFFFFFFFC);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h0BAD0001, 0);
        check("t5_pc_top", id_pc, 64'hFFFFFFFFFFFFFFFC);
        cycle(0, 0, 0, 0, 0);
        check("t5_wrap_line", 64'(ic_line_addr), 64'h0);
        cycle(0, 0, 1, 32'h0BAD0002, 1);
        cycle(0, 0, 0, 0, 1);
        check("t5_wrap_pc", id_pc, 64'h0);

        // 6: reset in the middle of a request, then a stray ack.
        do_reset(64'h5000);
        cycle(0, 0, 0, 0, 1);
        #1;
        reset = 1'b1;
        model_reset(64'h5000);
        #1;
        check("t6_async_req", 64'(ic_req), 64'h0);
        check("t6_async_pc", id_pc, 64'h0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        cycle(0, 0, 1, 32'h57A7057A, 1);
        check("t6_stray_ignored", 64'(id_valid), 64'h0);
        check("t6_restart_line", 64'(ic_line_addr), 64'h140);
        cycle(0, 0, 0, 0, 1);

        // Random traffic: redirects, variable cache latency, bursty decode back-pressure.
        do_reset(64'h8000);
        for (int i = 0; i < 3000; i++) begin
            logic          rv;
            logic [AW-1:0] tgt;
            logic          ack;
            rv  = ($urandom_range(0, 99) < 6);
            tgt = ($urandom_range(0, 3) == 0) ? (64'hFFFFFFFFFFFFFFF0 | 64'($urandom_range(0, 15)))
                                              : {32'($urandom), 32'($urandom)};
            ack = m_busy && ($urandom_range(0, 1) == 1);
            cycle(rv, tgt, ack, 32'($urandom), ($urandom_range(0, 9) < 6));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
